bcd_operand_loader: RTL and testbench

- Upstream operand-entry stage for the one-digit BCD adder.
- Captures two BCD digits and a carry-in from the board switches, one per debounced press of a push button.
- Validates each digit and presents the stable operand set X, Y, Cin with a valid level and a one-cycle strobe.
- Its OP_* outputs connect directly to the adder's SW_X, SW_Y and SW_Cin inputs.

---
 rtl/bcd_operand_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_bcd_operand_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_loader.sv
// bcd_operand_loader
// Operand-entry front end for the one-digit BCD adder. A bouncy push button
// (KEY_1) is synchronized and debounced; each accepted press steps a small FSM
// that captures digit X, then digit Y together with the carry-in, and then
// presents the set as stable, valid operands.
//
// Optional build macro: BCD_LOADER_CHECK_EN
//   defined   -> digits above 9 are rejected and LED_ERR reports the rejection
//   undefined -> every 4-bit digit is accepted, LED_ERR is tied low and no
//                range comparator exists
//
// Handshake note: OP_VALID is a level that stays high while OP_X/OP_Y/OP_Cin
// hold a complete accepted set. OP_STROBE pulses for exactly the one cycle in
// which OP_VALID rises. The downstream adder consumes the set whenever
// OP_VALID is high; there is no ready/back-pressure path.
module bcd_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLOCK_50,
    input  logic       KEY_0,
    input  logic       KEY_1,
    input  logic [3:0] SW_D,
    input  logic       SW_Cin,
    output logic [3:0] OP_X,
    output logic [3:0] OP_Y,
    output logic       OP_Cin,
    output logic       OP_VALID,
    output logic       OP_STROBE,
    output logic       LED_ERR,
    output logic [1:0] LED_STATE
);

    typedef enum logic [1:0] {
        LOAD_X  = 2'b00,
        LOAD_Y  = 2'b01,
        READY   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button synchronizer and debouncer state
    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    logic             w_differ;
    logic             w_cnt_done;
    logic             w_fall;

    // FSM and captured operand registers
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_x;
    logic [3:0]       r_y;
    logic             r_cin;
    logic             r_valid;
    logic             r_strobe;
    logic [3:0]       w_x_nxt;
    logic [3:0]       w_y_nxt;
    logic             w_cin_nxt;
    logic             w_valid_nxt;
    logic             w_strobe_nxt;
    logic             w_digit_ok;

`ifdef BCD_LOADER_CHECK_EN
    logic             r_err;
    logic             w_err_nxt;
`endif

    // Two-flop synchronizer for the asynchronous button; idles released (1)
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= KEY_1;
            r_sync2 <= r_sync1;
        end
    end

    // The synchronized level must differ from the debounced level for
    // DEBOUNCE_CYCLES consecutive cycles before it is adopted.
    assign w_differ   = (r_sync2 != r_deb);
    assign w_cnt_done = w_differ && (r_cnt == CNT_LAST);
    // Debounced level is about to go 1 -> 0: that is a press.
    assign w_fall     = w_cnt_done && !r_sync2;

    // Debounce counter and debounced level
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_deb <= 1'b1;
            r_cnt <= '0;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_cnt_done) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Registered one-cycle press pulse, high the cycle the debounced level falls
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_fall;
        end
    end

    // Digit acceptance: range-checked only when the check is built in
`ifdef BCD_LOADER_CHECK_EN
    assign w_digit_ok = (SW_D <= 4'd9);
`else
    assign w_digit_ok = 1'b1;
`endif

    // Next-state and next-output decode; switches are only looked at on a press
    always_comb begin
        w_state_nxt  = r_state;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_cin_nxt    = r_cin;
        w_valid_nxt  = r_valid;
        w_strobe_nxt = 1'b0;
`ifdef BCD_LOADER_CHECK_EN
        w_err_nxt    = r_err;
`endif
        case (r_state)
            LOAD_X: begin
                if (r_press) begin
                    if (w_digit_ok) begin
                        w_x_nxt     = SW_D;
                        w_state_nxt = LOAD_Y;
`ifdef BCD_LOADER_CHECK_EN
                        w_err_nxt   = 1'b0;
                    end else begin
                        w_err_nxt   = 1'b1;
`endif
                    end
                end
            end
            LOAD_Y: begin
                if (r_press) begin
                    if (w_digit_ok) begin
                        w_y_nxt      = SW_D;
                        w_cin_nxt    = SW_Cin;
                        w_valid_nxt  = 1'b1;
                        w_strobe_nxt = 1'b1;
                        w_state_nxt  = READY;
`ifdef BCD_LOADER_CHECK_EN
                        w_err_nxt    = 1'b0;
                    end else begin
                        w_err_nxt    = 1'b1;
`endif
                    end
                end
            end
            READY: begin
                if (r_press) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = LOAD_X;
`ifdef BCD_LOADER_CHECK_EN
                    w_err_nxt   = 1'b0;
`endif
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean entry state
                w_valid_nxt = 1'b0;
                w_state_nxt = LOAD_X;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_state <= LOAD_X;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand, valid and strobe registers
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_x      <= 4'd0;
            r_y      <= 4'd0;
            r_cin    <= 1'b0;
            r_valid  <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_cin    <= w_cin_nxt;
            r_valid  <= w_valid_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

`ifdef BCD_LOADER_CHECK_EN
    // Error indicator register: set by a rejected digit, cleared by an accepted press
    always_ff @(posedge CLOCK_50 or negedge KEY_0) begin
        if (!KEY_0) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign LED_ERR = r_err;
`else
    assign LED_ERR = 1'b0;
`endif

    assign OP_X      = r_x;
    assign OP_Y      = r_y;
    assign OP_Cin    = r_cin;
    assign OP_VALID  = r_valid;
    assign OP_STROBE = r_strobe;
    assign LED_STATE = r_state;

endmodule

// File: tb/tb_bcd_operand_loader.sv
// tb_bcd_operand_loader
// Bench for bcd_operand_loader with a short debounce window (4 cycles).
// Operand sets are pushed to exp_q as the Y digit is entered and popped by the
// strobe monitor when OP_STROBE fires.
module tb_bcd_operand_loader;

  logic       CLOCK_50 = 1'b0;
  logic       KEY_0;
  logic       KEY_1;
  logic [3:0] SW_D;
  logic       SW_Cin;
  logic [3:0] OP_X;
  logic [3:0] OP_Y;
  logic       OP_Cin;
  logic       OP_VALID;
  logic       OP_STROBE;
  logic       LED_ERR;
  logic [1:0] LED_STATE;

  int n_tests = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  logic [8:0] exp_q[$];
  logic prev_strobe = 1'b0;
  logic prev_valid = 1'b0;

  bcd_operand_loader #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY_0    (KEY_0),
    .KEY_1    (KEY_1),
    .SW_D     (SW_D),
    .SW_Cin   (SW_Cin),
    .OP_X     (OP_X),
    .OP_Y     (OP_Y),
    .OP_Cin   (OP_Cin),
    .OP_VALID (OP_VALID),
    .OP_STROBE(OP_STROBE),
    .LED_ERR  (LED_ERR),
    .LED_STATE(LED_STATE)
  );

  // clock / reset block
  always #10 CLOCK_50 = ~CLOCK_50;

  // strobe monitor: pops expected operand set, checks one-cycle rising strobe
  always @(negedge CLOCK_50) begin
    logic [8:0] exp;
    if (KEY_0 && OP_STROBE) begin
      strobe_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got x=%0d y=%0d cin=%0d, expected no strobe", OP_X, OP_Y, OP_Cin);
      end else begin
        exp = exp_q.pop_front();
        if ({OP_X, OP_Y, OP_Cin, OP_VALID} !== {exp, 1'b1}) begin
          n_fail++;
          $display("FAIL strobe_operands: got x=%0d y=%0d cin=%0d v=%0d, expected x=%0d y=%0d cin=%0d v=1",
                   OP_X, OP_Y, OP_Cin, OP_VALID, exp[8:5], exp[4:1], exp[0]);
        end
      end
      n_tests++;
      if (prev_strobe !== 1'b0 || prev_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_shape: prev_strobe=%0b prev_valid=%0b, expected 0 0", prev_strobe, prev_valid);
      end
    end
    prev_strobe = OP_STROBE;
    prev_valid  = OP_VALID;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic do_press(input logic [3:0] d, input logic cin);
    SW_D   = d;
    SW_Cin = cin;
    KEY_1  = 1'b0;
    tick(10);
    KEY_1  = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    KEY_0 = 1'b0; KEY_1 = 1'b1; SW_D = 4'd0; SW_Cin = 1'b0;
    tick(3);
    n_tests++;
    if ({OP_X, OP_Y, OP_Cin, OP_VALID, OP_STROBE, LED_ERR, LED_STATE} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%0d y=%0d cin=%0b v=%0b s=%0b err=%0b st=%0d, expected all 0",
               OP_X, OP_Y, OP_Cin, OP_VALID, OP_STROBE, LED_ERR, LED_STATE);
    end
    KEY_0 = 1'b1;
    tick(2);
    do_press(4'd5, 1'b0);
    n_tests++;
    if (LED_STATE !== 2'b01 || OP_X !== 4'd5) begin
      n_fail++;
      $display("FAIL reset_first_x: st=%0d x=%0d, expected st=1 x=5", LED_STATE, OP_X);
    end
    // asynchronous reset in the middle of LOAD_Y
    KEY_0 = 1'b0;
    #1;
    n_tests++;
    if ({OP_X, OP_Y, OP_Cin, OP_VALID, OP_STROBE, LED_ERR, LED_STATE} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_mid_entry: x=%0d st=%0d v=%0b, expected all 0", OP_X, LED_STATE, OP_VALID);
    end
    tick(2);
    KEY_0 = 1'b1;
    tick(2);
    do_press(4'd2, 1'b0);
    n_tests++;
    if (LED_STATE !== 2'b01 || OP_X !== 4'd2 || OP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_reload_x: st=%0d x=%0d v=%0b, expected st=1 x=2 v=0", LED_STATE, OP_X, OP_VALID);
    end
    KEY_0 = 1'b0;
    tick(2);
    KEY_0 = 1'b1;
    tick(2);
  endtask

  task automatic test_normal_entry();
    int s0;
    do_press(4'd7, 1'b0);
    n_tests++;
    if (LED_STATE !== 2'b01 || OP_X !== 4'd7 || OP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL entry_x: st=%0d x=%0d v=%0b, expected st=1 x=7 v=0", LED_STATE, OP_X, OP_VALID);
    end
    exp_q.push_back({4'd7, 4'd8, 1'b1});
    s0 = strobe_cnt;
    do_press(4'd8, 1'b1);
    n_tests++;
    if ({OP_X, OP_Y, OP_Cin, OP_VALID, OP_STROBE, LED_ERR, LED_STATE} !== {4'd7, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10}) begin
      n_fail++;
      $display("FAIL entry_xy: x=%0d y=%0d cin=%0b v=%0b s=%0b err=%0b st=%0d, expected 7 8 1 1 0 0 2",
               OP_X, OP_Y, OP_Cin, OP_VALID, OP_STROBE, LED_ERR, LED_STATE);
    end
    n_tests++;
    if (strobe_cnt !== s0 + 1) begin
      n_fail++;
      $display("FAIL entry_strobe_count: got %0d strobes, expected 1", strobe_cnt - s0);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 3; i++) begin
      KEY_1 = 1'b0;
      tick(2);
      KEY_1 = 1'b1;
      tick(4);
    end
    n_tests++;
    if (LED_STATE !== 2'b10 || OP_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL bounce_reject: st=%0d v=%0b, expected st=2 v=1", LED_STATE, OP_VALID);
    end
    // clean press: pulse 6 cycles after the fall, state moves one cycle later
    KEY_1 = 1'b0;
    tick(6);
    n_tests++;
    if (LED_STATE !== 2'b10) begin
      n_fail++;
      $display("FAIL bounce_latency_early: st=%0d at cycle 6, expected 2", LED_STATE);
    end
    tick(1);
    n_tests++;
    if (LED_STATE !== 2'b00 || OP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_latency: st=%0d v=%0b at cycle 7, expected st=0 v=0", LED_STATE, OP_VALID);
    end
    tick(3);
    KEY_1 = 1'b1;
    tick(10);
    n_tests++;
    if (LED_STATE !== 2'b00 || OP_X !== 4'd7 || OP_Y !== 4'd8) begin
      n_fail++;
      $display("FAIL bounce_single_press: st=%0d x=%0d y=%0d, expected st=0 x=7 y=8", LED_STATE, OP_X, OP_Y);
    end
  endtask

  task automatic test_range();
`ifdef BCD_LOADER_CHECK_EN
    do_press(4'd12, 1'b0);
    n_tests++;
    if (LED_ERR !== 1'b1 || LED_STATE !== 2'b00 || OP_X !== 4'd7) begin
      n_fail++;
      $display("FAIL range_x_reject: err=%0b st=%0d x=%0d, expected err=1 st=0 x=7", LED_ERR, LED_STATE, OP_X);
    end
    do_press(4'd3, 1'b0);
    n_tests++;
    if (LED_ERR !== 1'b0 || LED_STATE !== 2'b01 || OP_X !== 4'd3) begin
      n_fail++;
      $display("FAIL range_x_accept: err=%0b st=%0d x=%0d, expected err=0 st=1 x=3", LED_ERR, LED_STATE, OP_X);
    end
    do_press(4'd10, 1'b1);
    n_tests++;
    if (LED_ERR !== 1'b1 || LED_STATE !== 2'b01 || OP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL range_y_reject: err=%0b st=%0d v=%0b, expected err=1 st=1 v=0", LED_ERR, LED_STATE, OP_VALID);
    end
    exp_q.push_back({4'd3, 4'd9, 1'b0});
    do_press(4'd9, 1'b0);
    n_tests++;
    if (LED_ERR !== 1'b0 || LED_STATE !== 2'b10 || OP_Y !== 4'd9 || OP_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL range_y_accept: err=%0b st=%0d y=%0d v=%0b, expected err=0 st=2 y=9 v=1",
               LED_ERR, LED_STATE, OP_Y, OP_VALID);
    end
`else
    do_press(4'd15, 1'b0);
    n_tests++;
    if (LED_ERR !== 1'b0 || LED_STATE !== 2'b01 || OP_X !== 4'd15) begin
      n_fail++;
      $display("FAIL range_x_any: err=%0b st=%0d x=%0d, expected err=0 st=1 x=15", LED_ERR, LED_STATE, OP_X);
    end
    exp_q.push_back({4'd15, 4'd14, 1'b0});
    do_press(4'd14, 1'b0);
    n_tests++;
    if (LED_ERR !== 1'b0 || LED_STATE !== 2'b10 || OP_X !== 4'd15 || OP_Y !== 4'd14 || OP_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL range_y_any: err=%0b st=%0d x=%0d y=%0d v=%0b, expected err=0 st=2 x=15 y=14 v=1",
               LED_ERR, LED_STATE, OP_X, OP_Y, OP_VALID);
    end
`endif
  endtask

  task automatic test_restart();
    logic [3:0] hx;
    logic [3:0] hy;
    logic       hc;
`ifdef BCD_LOADER_CHECK_EN
    hx = 4'd3; hy = 4'd9; hc = 1'b0;
`else
    hx = 4'd15; hy = 4'd14; hc = 1'b0;
`endif
    do_press(4'd1, 1'b1);
    n_tests++;
    if (OP_VALID !== 1'b0 || LED_STATE !== 2'b00 || LED_ERR !== 1'b0 ||
        OP_X !== hx || OP_Y !== hy || OP_Cin !== hc) begin
      n_fail++;
      $display("FAIL restart: v=%0b st=%0d err=%0b x=%0d y=%0d cin=%0b, expected v=0 st=0 err=0 x=%0d y=%0d cin=%0b",
               OP_VALID, LED_STATE, LED_ERR, OP_X, OP_Y, OP_Cin, hx, hy, hc);
    end
    for (int i = 0; i < 20; i++) begin
      SW_D   = 4'($urandom_range(0, 15));
      SW_Cin = 1'($urandom_range(0, 1));
      tick(1);
    end
    n_tests++;
    if (OP_X !== hx || LED_STATE !== 2'b00) begin
      n_fail++;
      $display("FAIL switch_isolation: x=%0d st=%0d, expected x=%0d st=0", OP_X, LED_STATE, hx);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] x;
    logic [3:0] y;
    logic       c;
    for (int i = 0; i < 6; i++) begin
      x = 4'($urandom_range(0, 9));
      y = 4'($urandom_range(0, 9));
      c = 1'($urandom_range(0, 1));
      do_press(x, 1'b0);
      exp_q.push_back({x, y, c});
      do_press(y, c);
      n_tests++;
      if (LED_STATE !== 2'b10 || OP_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: st=%0d v=%0b, expected st=2 v=1", i, LED_STATE, OP_VALID);
      end
      do_press(4'($urandom_range(0, 15)), 1'b0);
    end
    n_tests++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal_entry();
    test_bounce();
    test_range();
    test_restart();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
